// File: rtl/pparch_harris_sub_pipe.sv
// pparch_harris_sub_pipe: two-stage pipelined Harris prefix subtractor.
// diff = a - b - bin is formed as a + ~b + ~bin, with ~bin entering the tree as
// an extra generate node below bit 0. The tree is sparse: span-doubling cells
// run only on odd nodes, and a trailing grey stage fills in the even nodes.
// Stage 1 holds the tree after the span-1/2 levels. Stage 2 finishes the tree
// and registers the result and flags. A valid/ready handshake with full
// backpressure sits around both stages.
module pparch_harris_sub_pipe #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // Tree node 0 is the carry-in (~bin). Node i+1 is operand bit i.
  localparam int N      = WIDTH + 1;
  localparam int LEVELS = $clog2(N);

  // One sparse level: every odd node at or above the span merges with the node
  // one span below it. All other nodes pass straight through.
  function automatic logic [2*N-1:0] sparse_level(input logic [N-1:0] g,
                                                  input logic [N-1:0] p,
                                                  input int lvl);
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    int span;
    int lo;
    gn   = g;
    pn   = p;
    span = 1 << lvl;
    for (int j = 1; j < N; j++) begin
      lo = (j >= span) ? (j - span) : 0;
      if ((j % 2 == 1) && (j >= span)) begin
        gn[j] = g[j] | (p[j] & g[lo]);
        pn[j] = p[j] & p[lo];
      end
    end
    return {pn, gn};
  endfunction

  // Trailing grey stage. Each even node absorbs the finished prefix of the odd
  // node directly below it.
  function automatic logic [N-1:0] grey_stage(input logic [N-1:0] g,
                                              input logic [N-1:0] p);
    logic [N-1:0] gn;
    gn = g;
    for (int j = 2; j < N; j += 2) begin
      gn[j] = g[j] | (p[j] & g[j-1]);
    end
    return gn;
  endfunction

  // Handshake.
  logic adv1;
  logic adv2;
  logic s1_valid;

  // Stage-1 combinational tree (span 1 and span 2).
  logic [WIDTH-1:0] nb;
  logic [N-1:0]     g_in;
  logic [N-1:0]     p_in;
  logic [2*N-1:0]   lvl0;
  logic [2*N-1:0]   lvl1;

  // Stage-1 registers.
  logic [N-1:0]     s1_g;
  logic [N-1:0]     s1_p;
  logic [WIDTH-1:0] s1_pb;
  logic             s1_amsb;
  logic             s1_bmsb;

  // Stage-2 combinational completion.
  logic [N-1:0]     gx;
  logic [N-1:0]     px;
  logic [N-1:0]     gf;
  logic [WIDTH-1:0] carry;
  logic             cout;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;
  logic             zero_d;
  logic             neg_d;
  logic             ovf_d;

  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  assign nb   = ~b;
  assign g_in = {a & nb, ~bin};
  assign p_in = {a ^ nb, 1'b0};
  assign lvl0 = sparse_level(g_in, p_in, 0);
  assign lvl1 = sparse_level(lvl0[N-1:0], lvl0[2*N-1:N], 1);

  // Stage 1: capture the half-built tree, bit propagates and sign bits of an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_pb    <= '0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g    <= lvl1[N-1:0];
        s1_p    <= lvl1[2*N-1:N];
        s1_pb   <= a ^ nb;
        s1_amsb <= a[WIDTH-1];
        s1_bmsb <= b[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational: remaining span-doubling levels, then the grey stage.
  always_comb begin
    gx = s1_g;
    px = s1_p;
    for (int k = 2; k < LEVELS; k++) begin
      {px, gx} = sparse_level(gx, px, k);
    end
    gf = grey_stage(gx, px);
  end

  // Node i holds the carry into bit i. The top node is the carry out of the MSB.
  assign carry  = gf[WIDTH-1:0];
  assign cout   = gf[N-1];
  assign diff_d = s1_pb ^ carry;
  assign bout_d = ~cout;
  assign zero_d = (diff_d == '0);
  assign neg_d  = diff_d[WIDTH-1];
  assign ovf_d  = (s1_amsb != s1_bmsb) & (diff_d[WIDTH-1] != s1_amsb);

  // Stage 2: register the result and flags. They stay frozen while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        diff <= diff_d;
        bout <= bout_d;
        zero <= zero_d;
        neg  <= neg_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pparch_harris_sub_pipe.sv
// Testbench for pparch_harris_sub_pipe.
// A monitor scoreboards every handshake against an arithmetic model. Scenario
// tasks drive stimulus and also check latency, ready and exact values inline.
module tb_pparch_harris_sub_pipe;

  typedef struct packed {
    logic [11:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int   checks;
  int   errors;
  int   accepted;
  int   retired;
  res_t q[$];
  logic stall_prev;
  res_t held;

  // Directed vectors and their hand-derived results.
  localparam logic [11:0] VA  [6] = '{12'h005, 12'h000, 12'h7A3, 12'h800, 12'h7FF, 12'h555};
  localparam logic [11:0] VB  [6] = '{12'h003, 12'h001, 12'h7A2, 12'h001, 12'h800, 12'h555};
  localparam logic        VBI [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] VEXP[6] = '{{12'h002, 4'b0000}, {12'hFFF, 4'b1010}, {12'h000, 4'b0100},
                                      {12'h7FF, 4'b0001}, {12'hFFF, 4'b1011}, {12'hFFF, 4'b1010}};

  pparch_harris_sub_pipe #(.WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic res_t ref_model(input logic [11:0] x, input logic [11:0] y, input logic bi);
    res_t e;
    int ua, ub, ib, r, sa, sb, sr;
    ua = int'(x);
    ub = int'(y);
    ib = bi ? 1 : 0;
    r  = ua - ub - ib;
    e.diff = 12'(r & 4095);
    e.bout = (ua < ub + ib);
    e.zero = ((r & 4095) == 0);
    e.neg  = ((r & 4095) >= 2048);
    sa = (ua >= 2048) ? ua - 4096 : ua;
    sb = (ub >= 2048) ? ub - 4096 : ub;
    sr = sa - sb - ib;
    e.ovf  = (sr > 2047) || (sr < -2048);
    return e;
  endfunction

  // Monitor: samples 2 time units after each falling edge. It checks retiring
  // beats and stall stability, and queues the expected result of each accepted beat.
  initial begin
    res_t act;
    res_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      act = {diff, bout, zero, neg, ovf};
      if (rst) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (act !== held) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %h required %h", act, held);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_beat: got %h required no beat", act);
          end else begin
            e = q.pop_front();
            if (act !== e) begin
              errors++;
              $display("[TB] FAIL result: got %h required %h", act, e);
            end
          end
          retired++;
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_model(a, b, bin));
          accepted++;
        end
        stall_prev = out_valid && !out_ready;
        held       = act;
      end
    end
  end

  // Drive one cycle's inputs on the falling edge, then return after the monitor has sampled.
  task automatic applyStimulus(input logic iv, input logic [11:0] ia, input logic [11:0] ib,
                               input logic ibin, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #3;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
    checks++;
    if ({diff, bout, zero, neg, ovf} !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h required 0000", {diff, bout, zero, neg, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_arith;
    res_t act;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, VA[i], VB[i], VBI[i], 1'b1);
      applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early %0d: got %b required 0", i, out_valid); end
      applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid %0d: got %b required 1", i, out_valid); end
      act = {diff, bout, zero, neg, ovf};
      checks++;
      if (act !== res_t'(VEXP[i])) begin
        errors++; $display("[TB] FAIL directed %0d: got %h required %h", i, act, VEXP[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = retired;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k < 8, 12'($urandom), 12'($urandom), 1'($urandom), 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready %0d: got %b required 1", k, in_ready); end
      checks++;
      if (out_valid !== (k >= 2)) begin
        errors++; $display("[TB] FAIL b2b_valid %0d: got %b required %b", k, out_valid, (k >= 2));
      end
    end
    checks++;
    if (retired - r0 != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 8", retired - r0); end
  endtask

  task automatic test_backpressure;
    int a0, r0, n;
    a0 = accepted;
    r0 = retired;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'b0);
      if (k >= 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready %0d: got %b required 0", k, in_ready); end
      end
    end
    checks++;
    if (accepted - a0 != 2) begin errors++; $display("[TB] FAIL bp_accepted: got %0d required 2", accepted - a0); end
    n = 0;
    while (q.size() != 0 && n < 10) begin
      applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (retired - r0 != 2) begin errors++; $display("[TB] FAIL bp_retired: got %0d required 2", retired - r0); end
  endtask

  task automatic test_reset_midstall;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midstall_full: got %b required 0", in_ready); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midstall_valid: got %b required 0", out_valid); end
    checks++;
    if ({diff, bout, zero, neg, ovf} !== 16'h0) begin
      errors++; $display("[TB] FAIL midstall_outputs: got %h required 0000", {diff, bout, zero, neg, ovf});
    end
    applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 12'h123, 12'h023, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b required 1", in_ready); end
    applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || diff !== 12'h100) begin
      errors++; $display("[TB] FAIL post_reset_diff: got %b/%h required 1/100", out_valid, diff);
    end
  endtask

  task automatic test_random;
    int a0, cyc, n;
    a0  = accepted;
    cyc = 0;
    while (accepted - a0 < 10000 && cyc < 40000) begin
      applyStimulus($urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom), 1'($urandom),
                    $urandom_range(0, 2) != 0);
      cyc++;
    end
    checks++;
    if (accepted - a0 < 10000) begin
      errors++; $display("[TB] FAIL random_budget: got %0d beats required 10000", accepted - a0);
    end
    n = 0;
    while (q.size() != 0 && n < 20) begin
      applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("[TB] FAIL random_drain: got %0d pending required 0", q.size()); end
  endtask

  // Watchdog so that a wedged pipe cannot hang the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    accepted  = 0;
    retired   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/pparch_harris_sub_pipe.md
Name: pparch_harris_sub_pipe

Overview:
- Pipelined 12-bit prefix subtractor: the inverse operator of the team's Harris prefix adder, sharing its black/grey cell style.
- Computes diff = a - b - bin with borrow-out and status flags.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Two register stages split the Harris prefix tree, with full backpressure support.

Parameters:
- WIDTH, 12, operand width; the prefix tree is built Harris-style (sparse span-doubling plus trailing grey stage) for any WIDTH >= 2; 12 is the signed-off configuration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result beat valid
- out_ready  input  1  sink accepts result beat
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow out; 1 iff unsigned a < b + bin
- zero  output  1  diff == 0
- neg  output  1  diff[WIDTH-1]
- ovf  output  1  signed overflow of a - b - bin

Behaviour:
- Arithmetic:
  - Implemented as a + ~b + cin with cin = ~bin.
  - p = a ^ ~b, g = a & ~b, and cin is injected as g[-1] exactly as in the adder.
  - bout = ~cout.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- Stage 1 (S1):
  - Registers p, g, cin, a[MSB], b[MSB] and the prefix-tree levels spanning 1 and 2 bits.
  - Holds s1_valid.
- Stage 2 (S2):
  - Completes the span-4/8 levels and the extra grey stage, then forms the carries, diff, bout and flags.
  - Registers these results as outputs and holds out_valid.
- Latency: 2 cycles from an accepted input beat to out_valid with no stall. Throughput: 1 beat per cycle.
- Advance rules:
  - adv2 = ~out_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1 (combinational; no combinational path from in_valid to in_ready).
- Transfers:
  - On adv1, S1 loads the operands and s1_valid <= in_valid.
  - On adv2, S2 loads from S1 and out_valid <= s1_valid.
  - Data registers are loaded only when the corresponding valid is 1; otherwise they hold.
- Stall:
  - While out_valid=1 and out_ready=0, diff, bout, zero, neg and ovf are held bit-stable.
  - S1 holds its beat. in_ready=0 only when S1 is also full.
- No beat is dropped or duplicated. Order is preserved.
- Simultaneous events: with out_ready=1, a full pipe and in_valid=1, the output beat retires, S1 moves to S2 and a new beat enters S1, all in the same cycle.
- Reset (async assert, any time including mid-stall):
  - s1_valid=0, out_valid=0.
  - diff=0, bout=0, zero=0, neg=0, ovf=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - In-flight beats are discarded.
- Wrap-around:
  - diff wraps modulo 2^WIDTH; no saturation.
  - bin=1 with a=b yields all-ones and bout=1.
- Flags are valid only when out_valid=1. They are registered with diff, never computed from live inputs.

Test Plan:
- a=0x005, b=0x003, bin=0, out_ready=1 -> 2 cycles later: diff=0x002, bout=0, zero=0, neg=0, ovf=0.
- a=0x000, b=0x001, bin=0 -> diff=0xFFF, bout=1, neg=1, ovf=0; then a=0x7A3, b=0x7A2, bin=1 -> diff=0x000, zero=1, bout=0.
- a=0x800, b=0x001, bin=0 -> diff=0x7FF, ovf=1, bout=0; a=0x7FF, b=0x800, bin=0 -> diff=0xFFF, ovf=1, bout=1.
- Back-to-back stream of 8 beats with out_ready=1 every cycle -> out_valid continuous from cycle 2, results in order, in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 beats accepted; diff/flags stable throughout; after release, all beats emerge in order with none lost.
- Assert rst while the pipe is full and stalled -> out_valid=0 and all outputs 0 immediately; after deassert, in_ready=1 and the next operand pair 0x123-0x023 yields diff=0x100 2 cycles later.
- Random: 10k random a/b/bin with random out_ready -> every output matches a scoreboard computing (a-b-bin) mod 4096 and the flags.
